// File: rtl/dvp2axis.sv
// dvp2axis: OV5640 8-bit DVP (RGB565, two bytes per pixel) to 24-bit RGB888
// AXI4-Stream with video framing (tuser = start of frame, tlast = end of line).
// Runs entirely in the camera pixel clock domain; a small FIFO absorbs tready
// back-pressure and counts pixels dropped when it is full.
module dvp2axis #(
    parameter int FIFO_DEPTH = 16,
    parameter bit VS_POL     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [23:0] axis_tdata,
    output logic        axis_tvalid,
    input  logic        axis_tready,
    output logic        axis_tlast,
    output logic        axis_tuser,
    output logic [2:0]  axis_tkeep,
    output logic [7:0]  frame_cnt,
    output logic [15:0] ovf_cnt,
    output logic [7:0]  odd_cnt,
    output logic [11:0] line_pix,
    output logic [11:0] frame_lines
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE
    } state_t;

    // Input stage and edge history
    logic          in_vsync_q, in_vsync_d;
    logic          in_href_q, in_href_d;
    logic [7:0]    in_data_q, in_data_d;
    logic          vs_prev_q, vs_prev_d;
    logic          href_prev_q, href_prev_d;

    // Capture state
    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [7:0]    b0_q, b0_d;
    logic          sof_q, sof_d;
    logic          hold_valid_q, hold_valid_d;
    logic [23:0]   hold_data_q, hold_data_d;
    logic          hold_user_q, hold_user_d;
    logic [11:0]   pix_ctr_q, pix_ctr_d;
    logic [11:0]   line_ctr_q, line_ctr_d;

    // Registered push request: {tuser, tlast, tdata}
    logic          push_q, push_d;
    logic [25:0]   push_data_q, push_data_d;

    // FIFO
    logic [25:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Status counters
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [15:0]   ovf_cnt_q, ovf_cnt_d;
    logic [7:0]    odd_cnt_q, odd_cnt_d;
    logic [11:0]   line_pix_q, line_pix_d;
    logic [11:0]   frame_lines_q, frame_lines_d;

    logic          vs_blank, vs_rise, vs_fall, href_fall, active;
    logic          pix_done, line_close;
    logic [11:0]   line_ctr_next;
    logic [4:0]    r5, b5;
    logic [5:0]    g6;
    logic [23:0]   new_pix;
    logic          fifo_full, fifo_empty, pop, wr_en;
    logic [25:0]   head;

    assign vs_blank  = (in_vsync_q == VS_POL);
    assign vs_rise   = vs_blank & ~vs_prev_q;
    assign vs_fall   = ~vs_blank & vs_prev_q;
    assign href_fall = href_prev_q & ~in_href_q;
    assign active    = (state_q == S_ACTIVE);

    // A vsync rise with HREF still high closes the open line; its byte is ignored
    assign pix_done   = active & ~vs_rise & in_href_q & phase_q;
    assign line_close = active & (href_fall | (vs_rise & in_href_q));

    assign r5      = b0_q[7:3];
    assign g6      = {b0_q[2:0], in_data_q[7:5]};
    assign b5      = in_data_q[4:0];
    assign new_pix = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = ~fifo_empty & axis_tready;
    assign wr_en      = push_q & (~fifo_full | pop);
    assign head       = mem_q[rd_ptr_q];

    assign axis_tvalid = ~fifo_empty;
    assign axis_tdata  = fifo_empty ? '0 : head[23:0];
    assign axis_tlast  = ~fifo_empty & head[24];
    assign axis_tuser  = ~fifo_empty & head[25];
    assign axis_tkeep  = 3'b111;

    assign frame_cnt   = frame_cnt_q;
    assign ovf_cnt     = ovf_cnt_q;
    assign odd_cnt     = odd_cnt_q;
    assign line_pix    = line_pix_q;
    assign frame_lines = frame_lines_q;

    // Next-state logic: framing FSM, byte pairing, hold register, FIFO, counters
    always_comb begin
        in_vsync_d    = cam_vsync;
        in_href_d     = cam_href;
        in_data_d     = cam_data;
        vs_prev_d     = vs_blank;
        href_prev_d   = in_href_q;
        state_d       = state_q;
        phase_d       = 1'b0;
        b0_d          = b0_q;
        sof_d         = sof_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        hold_user_d   = hold_user_q;
        pix_ctr_d     = pix_ctr_q;
        line_ctr_d    = line_ctr_q;
        push_d        = 1'b0;
        push_data_d   = push_data_q;
        frame_cnt_d   = frame_cnt_q;
        ovf_cnt_d     = ovf_cnt_q;
        odd_cnt_d     = odd_cnt_q;
        line_pix_d    = line_pix_q;
        frame_lines_d = frame_lines_q;
        line_ctr_next = line_ctr_q + {11'd0, line_close & hold_valid_q};

        if (active && in_href_q && !vs_rise) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                b0_d = in_data_q;
            end
        end

        if (pix_done) begin
            if (hold_valid_q) begin
                push_d      = 1'b1;
                push_data_d = {hold_user_q, 1'b0, hold_data_q};
            end
            hold_valid_d = 1'b1;
            hold_data_d  = new_pix;
            hold_user_d  = sof_q;
            sof_d        = 1'b0;
            pix_ctr_d    = pix_ctr_q + 12'd1;
        end

        if (line_close) begin
            if (hold_valid_q) begin
                push_d      = 1'b1;
                push_data_d = {hold_user_q, 1'b1, hold_data_q};
                line_pix_d  = pix_ctr_q;
            end
            if (phase_q && odd_cnt_q != 8'hFF) begin
                odd_cnt_d = odd_cnt_q + 8'd1;
            end
            hold_valid_d = 1'b0;
            pix_ctr_d    = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (vs_rise && en) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vs_fall) begin
                    state_d      = S_ACTIVE;
                    sof_d        = 1'b1;
                    line_ctr_d   = '0;
                    hold_valid_d = 1'b0;
                    pix_ctr_d    = '0;
                end
            end
            S_ACTIVE: begin
                line_ctr_d = line_ctr_next;
                if (vs_rise) begin
                    frame_lines_d = line_ctr_next;
                    if (line_ctr_next != '0) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                    state_d = en ? S_WAIT : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push_q && !wr_en && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(wr_en) - CW'(pop);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            in_vsync_q    <= VS_POL;
            in_href_q     <= 1'b0;
            in_data_q     <= '0;
            vs_prev_q     <= 1'b1;
            href_prev_q   <= 1'b0;
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            b0_q          <= '0;
            sof_q         <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
            hold_user_q   <= 1'b0;
            pix_ctr_q     <= '0;
            line_ctr_q    <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_cnt_q   <= '0;
            ovf_cnt_q     <= '0;
            odd_cnt_q     <= '0;
            line_pix_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            in_vsync_q    <= in_vsync_d;
            in_href_q     <= in_href_d;
            in_data_q     <= in_data_d;
            vs_prev_q     <= vs_prev_d;
            href_prev_q   <= href_prev_d;
            state_q       <= state_d;
            phase_q       <= phase_d;
            b0_q          <= b0_d;
            sof_q         <= sof_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            hold_user_q   <= hold_user_d;
            pix_ctr_q     <= pix_ctr_d;
            line_ctr_q    <= line_ctr_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_cnt_q   <= frame_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
            odd_cnt_q     <= odd_cnt_d;
            line_pix_q    <= line_pix_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

endmodule
